// File: rtl/fir_output_stage.sv
// rtl/fir_output_stage.sv - FIR chain output stage: fill discard, round/saturate, output FIFO.
// Drives the chain advance strobe under backpressure and buffers rounded samples for the consumer.
module fir_output_stage #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 7,
  parameter int FILL_LAT = 5,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         chain_ena,
  input  logic signed [IN_W-1:0]       y_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [OUT_W-1:0]      m_data,
  output logic                         sat_flag,
  output logic                         fill_done,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int FCW = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;

  localparam logic signed [IN_W:0] RND   = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [IN_W:0] MIN_V = -MAX_V - (IN_W + 1)'(1);

  typedef enum logic {FILL, RUN} state_t;

  state_t                    state, state_nxt;
  logic [FCW-1:0]            fill_cnt;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic signed [OUT_W-1:0]   mem [DEPTH];

  logic                      push, pop, fill_last;
  logic signed [IN_W:0]      rounded, shifted;
  logic                      sat_hi, sat_lo;
  logic signed [OUT_W-1:0]   sample;

  assign in_ready  = (level != LW'(DEPTH));
  assign chain_ena = in_valid & in_ready & ~clr;
  assign m_valid   = (level != '0);
  assign m_data    = mem[rd_ptr];
  assign fill_done = (state == RUN);

  assign push      = chain_ena & (state == RUN);
  assign pop       = m_valid & m_ready & ~clr;
  assign fill_last = (fill_cnt == FCW'(FILL_LAT - 1));

  // One extra bit of headroom keeps the rounding add from wrapping at full scale.
  assign rounded = $signed({y_in[IN_W-1], y_in}) + RND;
  assign shifted = rounded >>> SHIFT;
  assign sat_hi  = (shifted > MAX_V);
  assign sat_lo  = (shifted < MIN_V);
  assign sample  = sat_hi ? MAX_V[OUT_W-1:0] :
                   sat_lo ? MIN_V[OUT_W-1:0] : shifted[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)
      state_nxt = FILL;
    else if (state == FILL && chain_ena && fill_last)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fill_cnt <= '0;
    else if (clr)
      fill_cnt <= '0;
    else if (state == FILL && chain_ena)
      fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= sample;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && (sat_hi || sat_lo)) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_output_stage.sv
// tb/tb_fir_output_stage.sv - directed self-checking bench for fir_output_stage.
module tb_fir_output_stage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic               chain_ena;
  logic signed [31:0] y_in;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_data;
  logic               sat_flag;
  logic               fill_done;
  logic [2:0]         level;

  int n_checks = 0;
  int n_fail   = 0;

  fir_output_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain_ena (chain_ena),
    .y_in      (y_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .sat_flag  (sat_flag),
    .fill_done (fill_done),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; m_ready = 1'b0; y_in = 32'sd0;
    #2;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %0b expected 0", sat_flag); end
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done: got %0b expected 0", fill_done); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (chain_ena !== 1'b1) begin n_fail++; $display("FAIL reset_chain_ena: got %0b expected 1", chain_ena); end
    n_checks++; if (m_data !== 16'sd0) begin n_fail++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_frozen_fill: got %0b expected 0", fill_done); end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_fill();
    y_in = 32'sd1000; in_valid = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fill_m_valid[%0d]: got %0b expected 0", i, m_valid); end
      n_checks++; if (fill_done !== (i == 5)) begin n_fail++; $display("FAIL fill_done[%0d]: got %0b expected %0b", i, fill_done, i == 5); end
    end
    tick();
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL first_m_valid: got %0b expected 1", m_valid); end
    n_checks++; if (m_data !== 16'sd8) begin n_fail++; $display("FAIL first_m_data: got %0d expected 8", m_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL first_level: got %0d expected 1", level); end
  endtask

  task automatic test_round();
    y_in = -32'sd1000; tick();
    n_checks++; if (m_data !== -16'sd8) begin n_fail++; $display("FAIL round_neg1000: got %0d expected -8", m_data); end
    y_in = 32'sd64; tick();
    n_checks++; if (m_data !== 16'sd1) begin n_fail++; $display("FAIL round_pos64: got %0d expected 1", m_data); end
    y_in = -32'sd64; tick();
    n_checks++; if (m_data !== 16'sd0) begin n_fail++; $display("FAIL round_neg64: got %0d expected 0", m_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL round_level: got %0d expected 1", level); end
  endtask

  task automatic test_saturate();
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_pre: got %0b expected 0", sat_flag); end
    y_in = 32'sh0100_0000; tick();
    n_checks++; if (m_data !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos: got %0d expected 32767", m_data); end
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_set: got %0b expected 1", sat_flag); end
    y_in = -32'sh0100_0000; tick();
    n_checks++; if (m_data !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg: got %0d expected -32768", m_data); end
    y_in = 32'sh7FFF_FFFF; tick();
    n_checks++; if (m_data !== 16'sd32767) begin n_fail++; $display("FAIL sat_max_nowrap: got %0d expected 32767", m_data); end
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_sticky: got %0b expected 1", sat_flag); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b0; tick();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL bp_drain: got %0d expected 0", level); end
    in_valid = 1'b1; m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      y_in = 32'(k * 128);
      tick();
      n_checks++; if (level !== 3'(k)) begin n_fail++; $display("FAIL bp_level[%0d]: got %0d expected %0d", k, level, k); end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %0b expected 0", in_ready); end
    n_checks++; if (chain_ena !== 1'b0) begin n_fail++; $display("FAIL bp_chain_ena_full: got %0b expected 0", chain_ena); end
    y_in = 32'sd9999; tick();
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_hold_level: got %0d expected 4", level); end
    n_checks++; if (m_data !== 16'sd1) begin n_fail++; $display("FAIL bp_hold_data: got %0d expected 1", m_data); end
    m_ready = 1'b1; tick();
    m_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL bp_pop_level: got %0d expected 3", level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_rise: got %0b expected 1", in_ready); end
    n_checks++; if (m_data !== 16'sd2) begin n_fail++; $display("FAIL bp_pop_head: got %0d expected 2", m_data); end
    m_ready = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      tick();
      n_checks++; if (m_data !== 16'(k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", k, m_data, k); end
    end
    tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b expected 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; m_ready = 1'b0;
    y_in = 32'sd1280; tick();
    y_in = 32'sd2560; tick();
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_setup: got %0d expected 2", level); end
    m_ready = 1'b1;
    y_in = 32'sd3840; tick();
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_level_a: got %0d expected 2", level); end
    n_checks++; if (m_data !== 16'sd20) begin n_fail++; $display("FAIL b2b_data_a: got %0d expected 20", m_data); end
    y_in = 32'sd5120; tick();
    n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_level_b: got %0d expected 2", level); end
    n_checks++; if (m_data !== 16'sd30) begin n_fail++; $display("FAIL b2b_data_b: got %0d expected 30", m_data); end
    in_valid = 1'b0; tick();
    n_checks++; if (m_data !== 16'sd40) begin n_fail++; $display("FAIL b2b_data_c: got %0d expected 40", m_data); end
    tick();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d expected 0", level); end
  endtask

  task automatic test_clear();
    in_valid = 1'b1; m_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      y_in = 32'(k * 128);
      tick();
    end
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL clr_setup: got %0d expected 3", level); end
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL clr_sat_before: got %0b expected 1", sat_flag); end
    clr = 1'b1; #1;
    n_checks++; if (chain_ena !== 1'b0) begin n_fail++; $display("FAIL clr_chain_ena: got %0b expected 0", chain_ena); end
    tick();
    clr = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_m_valid: got %0b expected 0", m_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL clr_level: got %0d expected 0", level); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL clr_sat_flag: got %0b expected 0", sat_flag); end
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL clr_fill_done: got %0b expected 0", fill_done); end
    m_ready = 1'b1; y_in = 32'sh0100_0000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_refill_valid[%0d]: got %0b expected 0", i, m_valid); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL clr_fill_sat[%0d]: got %0b expected 0", i, sat_flag); end
    end
    n_checks++; if (fill_done !== 1'b1) begin n_fail++; $display("FAIL clr_refill_done: got %0b expected 1", fill_done); end
    y_in = 32'sd1000; tick();
    n_checks++; if (m_data !== 16'sd8) begin n_fail++; $display("FAIL clr_first_data: got %0d expected 8", m_data); end
    y_in = 32'sh7FFF_FFFF; tick();
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL clr_run_sat: got %0b expected 1", sat_flag); end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0; y_in = 32'sd256;
    tick(); tick();
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL arst_setup: got %0d expected 3", level); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_m_valid: got %0b expected 0", m_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", level); end
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL arst_fill_done: got %0b expected 0", fill_done); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL arst_sat_flag: got %0b expected 0", sat_flag); end
    n_checks++; if (m_data !== 16'sd0) begin n_fail++; $display("FAIL arst_m_data: got %0d expected 0", m_data); end
    #1 rst_n = 1'b1;
    y_in = 32'sd1000; m_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (m_valid !== 1'b0 || fill_done !== 1'b1) begin n_fail++; $display("FAIL arst_refill: got valid=%0b done=%0b expected valid=0 done=1", m_valid, fill_done); end
    tick();
    n_checks++; if (m_data !== 16'sd8 || m_valid !== 1'b1) begin n_fail++; $display("FAIL arst_first_data: got %0d valid=%0b expected 8 valid=1", m_data, m_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_round();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
